// File: rtl/l1_miss_handler.sv
// ---------------------------------------------------------------------------
// l1_miss_handler
//   Memory-side initiator for the L1 data cache. Accepts one line-miss request
//   from the dcache controller, writes the dirty victim line back to data
//   memory when required, then fetches the requested line and returns it.
//
//   Ports (cache side):
//     clk_i, rst_i        clock, asynchronous active-low reset
//     req_i               miss request, sampled only while idle
//     req_addr_i          byte address of the missing line
//     victim_dirty_i      victim must be written back before the refill
//     victim_addr_i       byte address of the victim line
//     victim_data_i       victim line contents
//     busy_o              request in progress
//     done_o              one-cycle pulse, refill_data_o valid
//     refill_data_o       fetched line, held until the next refill completes
//   Ports (memory side):
//     mem_enable_o        transaction request
//     mem_write_o         1 = write, 0 = read
//     mem_addr_o          line-aligned address
//     mem_data_o          write data
//     mem_data_i          read data, valid with mem_ack_i
//     mem_ack_i           single-cycle completion
//
//   Build option:
//     MISS_HANDLER_STATS_EN  adds refill_cnt_o / wb_cnt_o (32-bit, wrapping)
//                            counting read and write completions.
// ---------------------------------------------------------------------------
module l1_miss_handler #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned LINE_W   = 256,
  parameter int unsigned OFFSET_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              req_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              victim_dirty_i,
  input  logic [ADDR_W-1:0] victim_addr_i,
  input  logic [LINE_W-1:0] victim_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [LINE_W-1:0] refill_data_o,

  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
`ifdef MISS_HANDLER_STATS_EN
  output logic [31:0]       refill_cnt_o,
  output logic [31:0]       wb_cnt_o,
`endif
  output logic              mem_write_o
);

  localparam int unsigned CNT_W = 32;

  // Low OFFSET_W address bits select a byte within a line.
  localparam logic [ADDR_W-1:0] OFFSET_MASK =
    ADDR_W'((64'd1 << OFFSET_W) - 64'd1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB,
    ST_GAP,
    ST_RD,
    ST_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] req_line_q;   // aligned refill address, held until RD

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return a & ~OFFSET_MASK;
  endfunction

  // Miss sequencer; all outputs are registered so nothing reaches an output
  // combinationally from an input.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= ST_IDLE;
      req_line_q    <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      refill_data_o <= '0;
      mem_enable_o  <= 1'b0;
      mem_write_o   <= 1'b0;
      mem_addr_o    <= '0;
      mem_data_o    <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_i) begin
            // Latch the whole request once; inputs are ignored until IDLE.
            req_line_q   <= line_align(req_addr_i);
            mem_data_o   <= victim_data_i;
            busy_o       <= 1'b1;
            mem_enable_o <= 1'b1;
            if (victim_dirty_i) begin
              state       <= ST_WB;
              mem_write_o <= 1'b1;
              mem_addr_o  <= line_align(victim_addr_i);
            end else begin
              state       <= ST_RD;
              mem_write_o <= 1'b0;
              mem_addr_o  <= line_align(req_addr_i);
            end
          end
        end

        ST_WB: begin
          if (mem_ack_i) begin
            state        <= ST_GAP;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
          end
        end

        // One cycle with enable low separates the write from the read.
        ST_GAP: begin
          state        <= ST_RD;
          mem_enable_o <= 1'b1;
          mem_write_o  <= 1'b0;
          mem_addr_o   <= req_line_q;
        end

        ST_RD: begin
          if (mem_ack_i) begin
            state         <= ST_DONE;
            refill_data_o <= mem_data_i;
            done_o        <= 1'b1;
            mem_enable_o  <= 1'b0;
          end
        end

        ST_DONE: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end

        default: begin
          state        <= ST_IDLE;
          busy_o       <= 1'b0;
          mem_enable_o <= 1'b0;
          mem_write_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MISS_HANDLER_STATS_EN
  logic wb_ack;
  logic rd_ack;

  // Completions only count while a transaction of that kind is outstanding.
  assign wb_ack = (state == ST_WB) && mem_ack_i;
  assign rd_ack = (state == ST_RD) && mem_ack_i;

  // Free-running completion counters; wrap naturally at 2^32.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      refill_cnt_o <= '0;
      wb_cnt_o     <= '0;
    end else begin
      if (rd_ack) refill_cnt_o <= refill_cnt_o + CNT_W'(1);
      if (wb_ack) wb_cnt_o     <= wb_cnt_o + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_l1_miss_handler.sv
// ---------------------------------------------------------------------------
// tb_l1_miss_handler
//   Self-checking bench for l1_miss_handler. A cycle-stepped memory responder
//   with per-transaction latency records every memory transaction; each test
//   compares the recorded transactions and timing against values derived from
//   the miss-handling rules (transaction list, aligned addresses, latencies).
// ---------------------------------------------------------------------------
module tb_l1_miss_handler;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned LINE_W   = 256;
  localparam int unsigned OFFSET_W = 5;
  localparam int unsigned MAX_TX   = 4;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              req_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic              victim_dirty_i;
  logic [ADDR_W-1:0] victim_addr_i;
  logic [LINE_W-1:0] victim_data_i;
  logic              busy_o;
  logic              done_o;
  logic [LINE_W-1:0] refill_data_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;
  logic [LINE_W-1:0] mem_data_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_enable_o;
  logic              mem_write_o;
`ifdef MISS_HANDLER_STATS_EN
  logic [31:0]       refill_cnt_o;
  logic [31:0]       wb_cnt_o;
`endif

  l1_miss_handler #(
    .ADDR_W  (ADDR_W),
    .LINE_W  (LINE_W),
    .OFFSET_W(OFFSET_W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .req_i         (req_i),
    .req_addr_i    (req_addr_i),
    .victim_dirty_i(victim_dirty_i),
    .victim_addr_i (victim_addr_i),
    .victim_data_i (victim_data_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .refill_data_o (refill_data_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i),
    .mem_data_o    (mem_data_o),
    .mem_addr_o    (mem_addr_o),
    .mem_enable_o  (mem_enable_o),
`ifdef MISS_HANDLER_STATS_EN
    .refill_cnt_o  (refill_cnt_o),
    .wb_cnt_o      (wb_cnt_o),
`endif
    .mem_write_o   (mem_write_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Observations of one miss, filled by run_miss.
  logic [ADDR_W-1:0] o_addr  [MAX_TX];
  logic              o_wr    [MAX_TX];
  logic [LINE_W-1:0] o_data  [MAX_TX];
  int                o_start [MAX_TX];
  int                o_len   [MAX_TX];
  int                o_ntx, o_done_cnt, o_done_cyc, o_busy, o_unstable, acc;
  logic [LINE_W-1:0] o_refill;
  logic              o_idle_after, o_timeout;

  // Inputs presented while busy when run_miss keeps req_i asserted.
  logic [ADDR_W-1:0] nxt_ra, nxt_va;
  logic              nxt_dirty;
  logic [LINE_W-1:0] nxt_vd;

  // Expected completion counts.
  int exp_wb = 0;
  int exp_rf = 0;

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] aligned(input logic [ADDR_W-1:0] a);
    return a - (a % 32'd32);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Issues one miss from an idle cycle and plays the memory for it. Cycle ids:
  // the cycle right after edge k is cycle k+1; acc is the accepting edge.
  task automatic run_miss(input logic [ADDR_W-1:0] ra, input logic dirty,
                          input logic [ADDR_W-1:0] va, input logic [LINE_W-1:0] vd,
                          input int lw, input int lr, input logic [LINE_W-1:0] rd,
                          input logic keep, input logic noise);
    logic              prev_en, w0, post;
    logic [ADDR_W-1:0] a0;
    logic [LINE_W-1:0] d0;
    int                cur_len, lat;
    req_i = 1'b1; req_addr_i = ra; victim_dirty_i = dirty;
    victim_addr_i = va; victim_data_i = vd;
    step();
    acc = cyc;
    if (keep) begin
      req_addr_i = nxt_ra; victim_dirty_i = nxt_dirty;
      victim_addr_i = nxt_va; victim_data_i = nxt_vd;
    end else begin
      req_i = 1'b0; req_addr_i = $urandom; victim_dirty_i = 1'($urandom);
      victim_addr_i = $urandom; victim_data_i = rand_line();
    end
    o_ntx = 0; o_done_cnt = 0; o_done_cyc = -1; o_busy = 0; o_unstable = 0;
    o_refill = '0; o_idle_after = 1'b0; o_timeout = 1'b1;
    prev_en = 1'b0; post = 1'b0; cur_len = 0; a0 = '0; w0 = 1'b0; d0 = '0;
    for (int k = 0; k < 400; k++) begin
      mem_ack_i  = 1'b0;
      mem_data_i = rand_line();
      if (busy_o === 1'b1) o_busy++;
      if (done_o === 1'b1) begin
        o_done_cnt++; o_done_cyc = cyc + 1; o_refill = refill_data_o;
      end
      if (mem_enable_o === 1'b1) begin
        if (!prev_en) begin
          a0 = mem_addr_o; w0 = mem_write_o; d0 = mem_data_o; cur_len = 0;
          if (o_ntx < MAX_TX) begin
            o_addr[o_ntx] = a0; o_wr[o_ntx] = w0; o_data[o_ntx] = d0;
            o_start[o_ntx] = cyc + 1;
          end
          o_ntx++;
        end else if (mem_addr_o !== a0 || mem_write_o !== w0 || mem_data_o !== d0) begin
          o_unstable++;
        end
        cur_len++;
        if (o_ntx <= MAX_TX) o_len[o_ntx-1] = cur_len;
        lat = w0 ? lw : lr;
        if (cur_len == lat) begin
          mem_ack_i = 1'b1;
          if (!w0) mem_data_i = rd;
        end
      end else if (noise && $urandom_range(0, 1) == 1) begin
        mem_ack_i = 1'b1;   // stray ack while no transaction is open
      end
      prev_en = (mem_enable_o === 1'b1);
      if (post) begin
        o_idle_after = (busy_o === 1'b0);
        o_timeout = 1'b0;
        mem_ack_i = 1'b0;
        break;
      end
      if (done_o === 1'b1) post = 1'b1;
      step();
    end
    if (dirty) exp_wb++;
    exp_rf++;
  endtask

  task automatic test_reset();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b expected 0", done_o); end
    checks++; if (refill_data_o !== '0) begin errors++; $display("FAIL rst_refill: got %0h expected 0", refill_data_o); end
    checks++; if (mem_enable_o !== 1'b0) begin errors++; $display("FAIL rst_enable: got %0b expected 0", mem_enable_o); end
    checks++; if (mem_write_o !== 1'b0) begin errors++; $display("FAIL rst_write: got %0b expected 0", mem_write_o); end
    checks++; if (mem_addr_o !== '0) begin errors++; $display("FAIL rst_addr: got %0h expected 0", mem_addr_o); end
    checks++; if (mem_data_o !== '0) begin errors++; $display("FAIL rst_wdata: got %0h expected 0", mem_data_o); end
`ifdef MISS_HANDLER_STATS_EN
    checks++; if (refill_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_refill_cnt: got %0d expected 0", refill_cnt_o); end
    checks++; if (wb_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_wb_cnt: got %0d expected 0", wb_cnt_o); end
`endif
  endtask

  task automatic test_clean_miss();
    logic [LINE_W-1:0] a5;
    a5 = {32{8'hA5}};
    run_miss(32'h0000_0144, 1'b0, $urandom, rand_line(), 10, 10, a5, 1'b0, 1'b0);
    checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL clean_timeout: got %0b expected 0", o_timeout); end
    checks++; if (o_ntx != 1) begin errors++; $display("FAIL clean_ntx: got %0d expected 1", o_ntx); end
    checks++; if (o_addr[0] !== 32'h0000_0140 || o_wr[0] !== 1'b0) begin errors++; $display("FAIL clean_read: got addr %0h wr %0b expected 140/0", o_addr[0], o_wr[0]); end
    checks++; if (o_done_cyc - acc != 11) begin errors++; $display("FAIL clean_done_delay: got %0d expected 11", o_done_cyc - acc); end
    checks++; if (o_busy != 11) begin errors++; $display("FAIL clean_busy_cycles: got %0d expected 11", o_busy); end
    checks++; if (o_refill !== a5) begin errors++; $display("FAIL clean_refill: got %0h expected %0h", o_refill, a5); end
    checks++; if (refill_data_o !== a5) begin errors++; $display("FAIL clean_refill_hold: got %0h expected %0h", refill_data_o, a5); end
  endtask

  task automatic test_dirty_miss();
    logic [LINE_W-1:0] rd;
    rd = rand_line();
    run_miss(32'h0000_0040, 1'b1, 32'h0000_0380, 256'h1234, 10, 10, rd, 1'b0, 1'b0);
    checks++; if (o_ntx != 2) begin errors++; $display("FAIL dirty_ntx: got %0d expected 2", o_ntx); end
    if (o_ntx == 2) begin
      checks++; if (o_addr[0] !== 32'h380 || o_wr[0] !== 1'b1) begin errors++; $display("FAIL dirty_write: got addr %0h wr %0b expected 380/1", o_addr[0], o_wr[0]); end
      checks++; if (o_data[0] !== 256'h1234) begin errors++; $display("FAIL dirty_wdata: got %0h expected 1234", o_data[0]); end
      checks++; if (o_start[1] - (o_start[0] + o_len[0]) != 1) begin errors++; $display("FAIL dirty_gap: got %0d expected 1", o_start[1] - (o_start[0] + o_len[0])); end
      checks++; if (o_addr[1] !== 32'h40 || o_wr[1] !== 1'b0) begin errors++; $display("FAIL dirty_read: got addr %0h wr %0b expected 40/0", o_addr[1], o_wr[1]); end
    end
    checks++; if (o_done_cyc - acc != 22) begin errors++; $display("FAIL dirty_done_delay: got %0d expected 22", o_done_cyc - acc); end
    checks++; if (o_refill !== rd) begin errors++; $display("FAIL dirty_refill: got %0h expected %0h", o_refill, rd); end
  endtask

  task automatic test_zero_wait();
    run_miss($urandom, 1'b1, $urandom, rand_line(), 1, 1, rand_line(), 1'b0, 1'b0);
    checks++; if (o_ntx != 2) begin errors++; $display("FAIL zw_ntx: got %0d expected 2", o_ntx); end
    if (o_ntx == 2) begin
      checks++; if (o_start[0] != acc + 1) begin errors++; $display("FAIL zw_wb_start: got %0d expected %0d", o_start[0], acc + 1); end
      checks++; if (o_start[1] != acc + 3) begin errors++; $display("FAIL zw_rd_start: got %0d expected %0d", o_start[1], acc + 3); end
    end
    checks++; if (o_done_cyc - acc != 4) begin errors++; $display("FAIL zw_done_delay: got %0d expected 4", o_done_cyc - acc); end
  endtask

  // req_i stays high; the next request's fields are presented while busy.
  task automatic test_back_to_back();
    logic [ADDR_W-1:0] a_ra, a_va;
    logic [LINE_W-1:0] a_vd, b_rd;
    int                a_done;
    a_ra = $urandom; a_va = $urandom; a_vd = rand_line(); b_rd = rand_line();
    nxt_ra = $urandom; nxt_va = $urandom; nxt_dirty = 1'b1; nxt_vd = rand_line();
    run_miss(a_ra, 1'b1, a_va, a_vd, 3, 2, rand_line(), 1'b1, 1'b0);
    a_done = o_done_cyc;
    checks++; if (o_ntx != 2) begin errors++; $display("FAIL b2b_a_ntx: got %0d expected 2", o_ntx); end
    checks++; if (o_data[0] !== a_vd || o_addr[0] !== aligned(a_va)) begin errors++; $display("FAIL b2b_a_write: got addr %0h expected %0h", o_addr[0], aligned(a_va)); end
    checks++; if (o_unstable != 0) begin errors++; $display("FAIL b2b_a_stable: got %0d expected 0", o_unstable); end
    checks++; if (o_idle_after !== 1'b1) begin errors++; $display("FAIL b2b_idle_gap: got %0b expected 1", o_idle_after); end
    run_miss(nxt_ra, nxt_dirty, nxt_va, nxt_vd, 2, 4, b_rd, 1'b0, 1'b0);
    checks++; if (acc != a_done + 1) begin errors++; $display("FAIL b2b_accept_edge: got %0d expected %0d", acc, a_done + 1); end
    checks++; if (o_ntx != 2) begin errors++; $display("FAIL b2b_b_ntx: got %0d expected 2", o_ntx); end
    if (o_ntx == 2) begin
      checks++; if (o_addr[0] !== aligned(nxt_va) || o_data[0] !== nxt_vd) begin errors++; $display("FAIL b2b_b_write: got addr %0h expected %0h", o_addr[0], aligned(nxt_va)); end
      checks++; if (o_addr[1] !== aligned(nxt_ra)) begin errors++; $display("FAIL b2b_b_read: got %0h expected %0h", o_addr[1], aligned(nxt_ra)); end
    end
    checks++; if (o_refill !== b_rd) begin errors++; $display("FAIL b2b_b_refill: got %0h expected %0h", o_refill, b_rd); end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] ra, va;
    logic              dirty;
    logic [LINE_W-1:0] vd, rd;
    int                lw, lr, ntx, ri, rd_start, done_at;
    for (int it = 0; it < 12; it++) begin
      ra = $urandom; va = $urandom; dirty = 1'($urandom); vd = rand_line(); rd = rand_line();
      lw = $urandom_range(1, 6); lr = $urandom_range(1, 6);
      run_miss(ra, dirty, va, vd, lw, lr, rd, 1'b0, 1'b1);
      ntx      = dirty ? 2 : 1;
      ri       = ntx - 1;
      rd_start = dirty ? acc + 1 + lw + 1 : acc + 1;
      done_at  = rd_start + lr;
      checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL rnd%0d_timeout: got %0b expected 0", it, o_timeout); end
      checks++; if (o_ntx != ntx) begin errors++; $display("FAIL rnd%0d_ntx: got %0d expected %0d", it, o_ntx, ntx); end
      if (o_ntx == ntx) begin
        if (dirty) begin
          checks++; if (o_addr[0] !== aligned(va) || o_wr[0] !== 1'b1 || o_data[0] !== vd) begin errors++; $display("FAIL rnd%0d_write: got addr %0h wr %0b expected %0h/1", it, o_addr[0], o_wr[0], aligned(va)); end
          checks++; if (o_start[0] != acc + 1 || o_len[0] != lw) begin errors++; $display("FAIL rnd%0d_write_time: got %0d/%0d expected %0d/%0d", it, o_start[0], o_len[0], acc + 1, lw); end
        end
        checks++; if (o_addr[ri] !== aligned(ra) || o_wr[ri] !== 1'b0) begin errors++; $display("FAIL rnd%0d_read: got addr %0h wr %0b expected %0h/0", it, o_addr[ri], o_wr[ri], aligned(ra)); end
        checks++; if (o_start[ri] != rd_start || o_len[ri] != lr) begin errors++; $display("FAIL rnd%0d_read_time: got %0d/%0d expected %0d/%0d", it, o_start[ri], o_len[ri], rd_start, lr); end
      end
      checks++; if (o_done_cnt != 1 || o_done_cyc != done_at) begin errors++; $display("FAIL rnd%0d_done: got %0d pulses at %0d expected 1 at %0d", it, o_done_cnt, o_done_cyc, done_at); end
      checks++; if (o_refill !== rd) begin errors++; $display("FAIL rnd%0d_refill: got %0h expected %0h", it, o_refill, rd); end
      checks++; if (o_busy != done_at - acc) begin errors++; $display("FAIL rnd%0d_busy: got %0d expected %0d", it, o_busy, done_at - acc); end
      checks++; if (o_unstable != 0) begin errors++; $display("FAIL rnd%0d_stable: got %0d expected 0", it, o_unstable); end
      checks++; if (o_idle_after !== 1'b1) begin errors++; $display("FAIL rnd%0d_idle: got %0b expected 1", it, o_idle_after); end
    end
  endtask

  // Reset during the read wait, then a stray ack once reset is released.
  task automatic test_reset_mid();
    int bad;
    mem_ack_i = 1'b0;
    req_i = 1'b1; req_addr_i = $urandom; victim_dirty_i = 1'b0;
    step();
    req_i = 1'b0;
    repeat (3) step();
    checks++; if (mem_enable_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre_enable: got %0b expected 1", mem_enable_o); end
    #2 rst_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || mem_enable_o !== 1'b0) begin errors++; $display("FAIL rstmid_async: got busy %0b en %0b expected 0/0", busy_o, mem_enable_o); end
    checks++; if (refill_data_o !== '0 || mem_addr_o !== '0 || mem_data_o !== '0 || mem_write_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: got addr %0h refill %0h expected 0/0", mem_addr_o, refill_data_o); end
    exp_wb = 0; exp_rf = 0;
    step();
    rst_i = 1'b1;
    mem_ack_i = 1'b1; mem_data_i = rand_line();
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      mem_ack_i = 1'b0;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || mem_enable_o !== 1'b0 || refill_data_o !== '0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_stray_ack: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_stats();
    run_miss($urandom, 1'b1, $urandom, rand_line(), 2, 3, rand_line(), 1'b0, 1'b1);
    run_miss($urandom, 1'b0, $urandom, rand_line(), 1, 5, rand_line(), 1'b0, 1'b1);
    run_miss($urandom, 1'b0, $urandom, rand_line(), 4, 1, rand_line(), 1'b0, 1'b1);
    checks++; if (o_done_cyc - acc != 2) begin errors++; $display("FAIL stats_last_done: got %0d expected 2", o_done_cyc - acc); end
`ifdef MISS_HANDLER_STATS_EN
    checks++; if (wb_cnt_o !== 32'(exp_wb)) begin errors++; $display("FAIL stats_wb_cnt: got %0d expected %0d", wb_cnt_o, exp_wb); end
    checks++; if (refill_cnt_o !== 32'(exp_rf)) begin errors++; $display("FAIL stats_refill_cnt: got %0d expected %0d", refill_cnt_o, exp_rf); end
`endif
  endtask

  initial begin
    rst_i = 1'b0; req_i = 1'b0; req_addr_i = '0; victim_dirty_i = 1'b0;
    victim_addr_i = '0; victim_data_i = '0; mem_data_i = '0; mem_ack_i = 1'b0;
    nxt_ra = '0; nxt_va = '0; nxt_dirty = 1'b0; nxt_vd = '0;
    repeat (3) step();
    test_reset();
    rst_i = 1'b1;
    step();
    test_clean_miss();
    test_dirty_miss();
    test_zero_wait();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l1_miss_handler.md
# l1_miss_handler

Memory-side initiator for the L1 data cache. On a cache miss it takes a single line request from the cache controller, writes back the dirty victim line to data memory if needed, then fetches the requested 256-bit line and returns it to the cache. It drives the same enable/write/ack memory interface that the data memory responds on, and sits between the dcache controller and the data memory inside the CPU.

## Interface

Parameters:
- ADDR_W, 32: byte address width.
- LINE_W, 256: cache line / memory unit width.
- OFFSET_W, 5: byte-offset bits within a line; forced to zero on mem_addr_o.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- req_i  in  1  miss request; sampled only while busy_o=0.
- req_addr_i  in  ADDR_W  byte address of missing line.
- victim_dirty_i  in  1  victim line must be written back first.
- victim_addr_i  in  ADDR_W  byte address of victim line.
- victim_data_i  in  LINE_W  victim line contents.
- busy_o  out  1  request in progress.
- done_o  out  1  one-cycle pulse: refill_data_o valid.
- refill_data_o  out  LINE_W  fetched line; holds until next refill completes.
- mem_data_i  in  LINE_W  read data from memory; valid with mem_ack_i.
- mem_ack_i  in  1  memory completion; one cycle.
- mem_data_o  out  LINE_W  write data.
- mem_addr_o  out  ADDR_W  line-aligned address.
- mem_enable_o  out  1  transaction request.
- mem_write_o  out  1  1=write, 0=read.

## Operation

- States: IDLE, WB, GAP, RD, DONE.
- IDLE: busy_o=0. If req_i=1, latch req_addr_i, victim_addr_i, victim_data_i; go WB if victim_dirty_i=1, else RD.
- WB: mem_enable_o=1, mem_write_o=1, mem_addr_o=victim address with low OFFSET_W bits zero, mem_data_o=latched victim data. On mem_ack_i=1 go GAP.
- GAP: mem_enable_o=0 for exactly one cycle; go RD.
- RD: mem_enable_o=1, mem_write_o=0, mem_addr_o=aligned req address. On mem_ack_i=1 capture mem_data_i into refill_data_o; go DONE.
- DONE: done_o=1, busy_o=1, mem_enable_o=0; go IDLE.
- Request fields are latched once; later changes on req/victim inputs have no effect until IDLE.
- mem_addr_o, mem_data_o, mem_write_o are stable for the whole time mem_enable_o=1.
- mem_ack_i is ignored in IDLE, GAP and DONE.

## Timing

- All outputs are registered/state-decoded; no combinational path from any input to any output.
- Reset values: busy_o=0, done_o=0, refill_data_o=0, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0; state IDLE.
- req_i high at edge N (IDLE) -> busy_o=1 and mem_enable_o=1 from cycle N+1.
- An ack in the first cycle enable is high is accepted (zero-wait responder).
- Clean miss, ack after L enable cycles: done_o in cycle N+1+L. Total busy cycles = L+1.
- Dirty miss, write ack after Lw and read ack after Lr: done_o in cycle N+1+Lw+1+Lr.
- mem_enable_o drops in the cycle after ack. There is always at least one idle cycle between the write and the read.
- A new req_i is accepted no earlier than the edge on which DONE exits. Back-to-back requests give one cycle of busy_o=0.
- Reset asserted mid-transaction: all outputs go to reset values immediately (asynchronously). The latched request is discarded and no done_o is produced.

## Configuration

- MISS_HANDLER_STATS_EN defined: adds ports refill_cnt_o (out, 32) and wb_cnt_o (out, 32).
  - refill_cnt_o increments on each read ack; wb_cnt_o increments on each write ack.
  - Both reset to 0 and wrap from 0xFFFFFFFF to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Test plan

- Clean miss: req_addr_i=0x0000_0144, victim_dirty_i=0, responder acks after 10 cycles with data 256'hA5..A5 -> one read at mem_addr_o=0x0000_0140; done_o pulses 11 cycles after acceptance; refill_data_o=256'hA5..A5.
- Dirty miss: victim_addr_i=0x0000_0380, victim_data_i=256'h1234, req_addr_i=0x0000_0040, acks at 10 cycles -> write at 0x380 with data 256'h1234, one gap cycle, read at 0x040; done_o 22 cycles after acceptance.
- Zero-wait responder (ack in the first enable cycle), dirty miss -> sequence WB, GAP, RD, DONE; done_o 4 cycles after acceptance.
- req_i held high continuously, and victim inputs changed while busy -> second request accepted only after the DONE cycle; its latched fields are the values present at that acceptance edge.
- rst_i pulsed low during RD wait -> mem_enable_o=0 and busy_o=0 immediately; no done_o. A spurious mem_ack_i after reset produces no state change.
- With MISS_HANDLER_STATS_EN: one dirty miss plus two clean misses -> wb_cnt_o=1, refill_cnt_o=3.
